// File: rtl/i2f_pkg.sv
// rtl/i2f_pkg.sv - shared types and helpers for the integer-to-minifloat converter
package i2f_pkg;

  typedef enum logic {
    RND_TRUNC = 1'b0,
    RND_RNE   = 1'b1
  } rnd_mode_e;

  // Widest operand the leading-one helper can scan
  localparam int LOD_W = 64;

  // Largest value the exponent field can encode
  function automatic int max_exp(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  // Bits needed for a bit index / shift amount inside an in_w-bit word
  function automatic int shift_w(input int in_w);
    return (in_w <= 2) ? 1 : $clog2(in_w);
  endfunction

  // Index of the most significant set bit; 0 when no bit is set
  function automatic int lod_idx(input logic [LOD_W-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < LOD_W; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/i2f_norm.sv
// rtl/i2f_norm.sv - leading-one detect and left-shift normaliser
module i2f_norm
  import i2f_pkg::*;
#(
  parameter int IN_W = 11,
  parameter int SH_W = shift_w(IN_W)
)(
  input  logic [IN_W-1:0] mag,
  output logic [SH_W-1:0] lead,
  output logic [IN_W-2:0] frac,
  output logic            zero
);

  logic [SH_W-1:0] shamt;

  // Shift the leading one off the top so frac holds the bits just below it, MSB-aligned
  always_comb begin
    lead  = SH_W'(lod_idx(LOD_W'(mag)));
    shamt = SH_W'(IN_W - 1) - lead;
    frac  = (IN_W-1)'(mag << shamt);
    zero  = ~|mag;
  end

endmodule

// File: rtl/int2float_pipe.sv
// rtl/int2float_pipe.sv - three-stage integer to minifloat converter with valid/ready
module int2float_pipe
  import i2f_pkg::*;
#(
  parameter int IN_W   = 11,
  parameter int MANT_W = 4,
  parameter int EXP_W  = 3,
  parameter bit SIGNED = 1'b0
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_rnd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_zero,
  output logic              out_inexact,
  output logic              out_ovf
);

  localparam int MAX_EXP = max_exp(EXP_W);
  localparam int SH_W    = shift_w(IN_W);
  localparam int F_W     = IN_W - 1;

  if (MAX_EXP < IN_W - MANT_W) begin : g_exp_too_narrow
    $error("int2float_pipe: EXP_W cannot cover the exponent range of IN_W/MANT_W");
  end
  if (IN_W < MANT_W + 2 || IN_W > LOD_W) begin : g_bad_in_w
    $error("int2float_pipe: IN_W out of supported range");
  end

  logic              adv;
  logic              neg;
  logic [IN_W-1:0]   abs_in;

  logic              s1_valid, s1_sign;
  logic [IN_W-1:0]   s1_mag;
  rnd_mode_e         s1_rnd;

  logic [SH_W-1:0]   n_lead;
  logic [F_W-1:0]    n_frac;
  logic              n_zero;

  logic              s2_valid, s2_sign, s2_zero, s2_sub;
  rnd_mode_e         s2_rnd;
  logic [SH_W-1:0]   s2_lead;
  logic [F_W-1:0]    s2_frac;
  logic [MANT_W-1:0] s2_low;

  logic [MANT_W-1:0] mant_t;
  logic [F_W-1:0]    low_bits;
  logic              guard, sticky, up;
  logic [MANT_W:0]   sum;
  int                e;
  logic [EXP_W-1:0]  r_exp;
  logic [MANT_W-1:0] r_mant;
  logic              r_inx, r_ovf;

  // One enable moves every stage; a held output freezes the whole pipe
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // Magnitude of the operand; the most negative value maps onto the top bit alone
  always_comb begin
    neg    = SIGNED && in_data[IN_W-1];
    abs_in = neg ? (~in_data + IN_W'(1)) : in_data;
  end

  // Stage 1: capture magnitude, sign and rounding mode of an accepted operand
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
      s1_rnd   <= RND_TRUNC;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= neg;
        s1_mag  <= abs_in;
        s1_rnd  <= rnd_mode_e'(in_rnd);
      end
    end
  end

  i2f_norm #(
    .IN_W (IN_W),
    .SH_W (SH_W)
  ) u_norm (
    .mag  (s1_mag),
    .lead (n_lead),
    .frac (n_frac),
    .zero (n_zero)
  );

  // Stage 2: hold the normalised fraction plus what rounding needs for subnormals
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_sub   <= 1'b0;
      s2_rnd   <= RND_TRUNC;
      s2_lead  <= '0;
      s2_frac  <= '0;
      s2_low   <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign <= s1_sign;
        s2_zero <= n_zero;
        s2_sub  <= (n_lead < SH_W'(MANT_W));
        s2_rnd  <= s1_rnd;
        s2_lead <= n_lead;
        s2_frac <= n_frac;
        s2_low  <= s1_mag[MANT_W-1:0];
      end
    end
  end

  // Round, handle mantissa carry into the exponent, and saturate past the top exponent
  always_comb begin
    mant_t   = s2_frac[F_W-1 -: MANT_W];
    guard    = s2_frac[F_W-1-MANT_W];
    low_bits = s2_frac << (MANT_W + 1);
    sticky   = |low_bits;
    up       = (s2_rnd == RND_RNE) && guard && (sticky || mant_t[0]);
    sum      = {1'b0, mant_t} + {{MANT_W{1'b0}}, up};
    e        = int'(s2_lead) - MANT_W + 1 + int'(sum[MANT_W]);
    r_exp    = '0;
    r_mant   = s2_low;
    r_inx    = 1'b0;
    r_ovf    = 1'b0;
    if (!s2_sub) begin
      r_inx = guard | sticky;
      if (e > MAX_EXP) begin
        r_exp  = '1;
        r_mant = '1;
        r_ovf  = 1'b1;
        r_inx  = 1'b1;
      end else begin
        r_exp  = EXP_W'(e);
        r_mant = sum[MANT_W-1:0];
      end
    end
  end

  // Stage 3: register the packed result; fields hold while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_sign    <= 1'b0;
      out_exp     <= '0;
      out_mant    <= '0;
      out_zero    <= 1'b0;
      out_inexact <= 1'b0;
      out_ovf     <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_sign    <= s2_sign;
        out_exp     <= r_exp;
        out_mant    <= r_mant;
        out_zero    <= s2_zero;
        out_inexact <= r_inx;
        out_ovf     <= r_ovf;
      end
    end
  end

endmodule

// File: tb/tb_int2float_pipe.sv
// tb/tb_int2float_pipe.sv - scoreboard bench for int2float_pipe (unsigned and signed instances)
module tb_int2float_pipe;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [7:0] mant;
    logic       zero;
    logic       inx;
    logic       ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_rnd = 1'b0;
  logic        out_ready = 1'b1;
  logic [10:0] u_data = '0;
  logic [11:0] s_data = '0;

  logic       u_in_ready, u_out_valid, u_sign, u_zero, u_inx, u_ovf;
  logic [2:0] u_exp;
  logic [3:0] u_mant;
  logic       s_in_ready, s_out_valid, s_sign, s_zero, s_inx, s_ovf;
  logic [3:0] s_exp;
  logic [3:0] s_mant;

  res_t qu[$];
  res_t qs[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_ready = 1'b0;

  int   dir_u[9] = '{0, 13, 1462, 1462, 33, 35, 31, 2047, 2047};
  int   dir_s[9] = '{0, -1024, -1462, -1462, -2048, 35, -31, 2047, 2047};
  bit   dir_r[9] = '{0, 0, 0, 1, 1, 1, 1, 1, 0};
  res_t dir_eu[9] = '{
    '{0, 0, 0, 1, 0, 0}, '{0, 0, 13, 0, 0, 0}, '{0, 7, 6, 0, 1, 0},
    '{0, 7, 7, 0, 1, 0}, '{0, 2, 0, 0, 1, 0},  '{0, 2, 2, 0, 1, 0},
    '{0, 1, 15, 0, 0, 0}, '{0, 7, 15, 0, 1, 1}, '{0, 7, 15, 0, 1, 0}};
  res_t dir_es[9] = '{
    '{0, 0, 0, 1, 0, 0}, '{1, 7, 0, 0, 0, 0},  '{1, 7, 6, 0, 1, 0},
    '{1, 7, 7, 0, 1, 0}, '{1, 8, 0, 0, 0, 0},  '{0, 2, 2, 0, 1, 0},
    '{1, 1, 15, 0, 0, 0}, '{0, 8, 0, 0, 1, 0}, '{0, 7, 15, 0, 1, 0}};
  int   pool[10] = '{0, 1, 15, 16, 17, 31, 32, 1023, 1024, 2047};

  int2float_pipe #(.IN_W(11), .MANT_W(4), .EXP_W(3), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready),
    .in_data(u_data), .in_rnd(in_rnd), .out_valid(u_out_valid), .out_ready(out_ready),
    .out_sign(u_sign), .out_exp(u_exp), .out_mant(u_mant), .out_zero(u_zero),
    .out_inexact(u_inx), .out_ovf(u_ovf));

  int2float_pipe #(.IN_W(12), .MANT_W(4), .EXP_W(4), .SIGNED(1'b1)) s_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(s_data), .in_rnd(in_rnd), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_sign(s_sign), .out_exp(s_exp), .out_mant(s_mant), .out_zero(s_zero),
    .out_inexact(s_inx), .out_ovf(s_ovf));

  always #5 clk = ~clk;

  // Reference: value = q * 2**(p-m) with q in [2**m, 2**(m+1)), rounded by integer division
  function automatic res_t model(input int in_w, input int mant_w, input int exp_w,
                                 input bit sgn, input int raw, input bit rnd);
    res_t   r;
    longint v, mag, scale, q, rem;
    int     p;
    r = '0;
    v = longint'(raw) & ((longint'(1) << in_w) - 1);
    if (sgn && v >= (longint'(1) << (in_w - 1))) v = v - (longint'(1) << in_w);
    r.sign = (v < 0);
    mag    = (v < 0) ? -v : v;
    r.zero = (mag == 0);
    if (mag < (longint'(1) << mant_w)) begin
      r.mant = 8'(mag);
      return r;
    end
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    scale = longint'(1) << (p - mant_w);
    q     = mag / scale;
    rem   = mag % scale;
    r.inx = (rem != 0);
    if (rnd && ((2 * rem > scale) || (2 * rem == scale && (q % 2) == 1))) q++;
    if (q == (longint'(2) << mant_w)) begin
      q = q / 2;
      p++;
    end
    if (p - mant_w + 1 > (1 << exp_w) - 1) begin
      r.exp  = 8'((1 << exp_w) - 1);
      r.mant = 8'((1 << mant_w) - 1);
      r.ovf  = 1'b1;
      r.inx  = 1'b1;
    end else begin
      r.exp  = 8'(p - mant_w + 1);
      r.mant = 8'(q - (longint'(1) << mant_w));
    end
    return r;
  endfunction

  function automatic string fmt(input res_t r);
    return $sformatf("sign=%0d exp=%0d mant=%0d zero=%0d inexact=%0d ovf=%0d",
                     r.sign, r.exp, r.mant, r.zero, r.inx, r.ovf);
  endfunction

  task automatic chk_res(input string name, input res_t act, input res_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %s, expected %s", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input int uv, input int sv, input bit rnd,
                      input bit use_lit, input res_t lu, input res_t ls);
    int waitc;
    bit done;
    waitc    = 0;
    done     = 1'b0;
    u_data   = 11'(uv);
    s_data   = 12'(sv);
    in_rnd   = rnd;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (u_in_ready) begin
        done = 1'b1;
        qu.push_back(use_lit ? lu : model(11, 4, 3, 1'b0, uv, rnd));
        qs.push_back(use_lit ? ls : model(12, 4, 4, 1'b1, sv, rnd));
      end else begin
        waitc++;
        if (waitc > 200) begin
          checks++;
          errors++;
          $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected acceptance", waitc);
          done = 1'b1;
        end
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((qu.size() != 0 || qs.size() != 0) && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (qu.size() != 0 || qs.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d/%0d pending, expected 0/0", tag, qu.size(), qs.size());
    end
  endtask

  // Monitor: scoreboard pops, in_ready rule, and output hold during stalls
  res_t act_u, act_s, held_u;
  bit   held_v = 1'b0;
  always @(negedge clk) begin
    act_u = '{u_sign, 8'(u_exp), 8'(u_mant), u_zero, u_inx, u_ovf};
    act_s = '{s_sign, 8'(s_exp), 8'(s_mant), s_zero, s_inx, s_ovf};
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      chk_bit("u_in_ready_rule", u_in_ready, out_ready | ~u_out_valid);
      chk_bit("s_in_ready_rule", s_in_ready, out_ready | ~s_out_valid);
      if (u_out_valid && out_ready) begin
        if (qu.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL u_unexpected_output: got %s, expected no output", fmt(act_u));
        end else begin
          chk_res("u_result", act_u, qu.pop_front());
        end
        held_v = 1'b0;
      end else if (u_out_valid) begin
        if (held_v) chk_res("u_stall_hold", act_u, held_u);
        held_u = act_u;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      if (s_out_valid && out_ready) begin
        if (qs.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL s_unexpected_output: got %s, expected no output", fmt(act_s));
        end else begin
          chk_res("s_result", act_s, qs.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   uv, sv;
    res_t zero_r;
    zero_r = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_bit("reset_u_out_valid", u_out_valid, 1'b0);
    chk_bit("reset_s_out_valid", s_out_valid, 1'b0);
    chk_bit("reset_in_ready", u_in_ready, 1'b1);
    chk_res("reset_u_fields", '{u_sign, 8'(u_exp), 8'(u_mant), u_zero, u_inx, u_ovf}, zero_r);
    rst_n = 1'b1;
    tick();

    send(dir_u[0], dir_s[0], dir_r[0], 1'b1, dir_eu[0], dir_es[0]);
    lat = 1;
    @(negedge clk);
    while (!u_out_valid && lat < 10) begin
      lat++;
      @(negedge clk);
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL latency: got %0d cycles, expected 3", lat);
    end
    tick();
    for (int i = 1; i < 9; i++) send(dir_u[i], dir_s[i], dir_r[i], 1'b1, dir_eu[i], dir_es[i]);
    drain("directed");

    fork
      begin
        for (int k = 0; k < 8; k++) begin
          send(16 + k * 250, (k % 2 == 0) ? -(17 + k * 230) : 17 + k * 230, 1'(k % 2),
               1'b0, zero_r, zero_r);
        end
      end
      begin
        for (int c = 0; c < 14; c++) begin
          out_ready = !(c >= 4 && c <= 9);
          @(negedge clk);
          if (c >= 4 && c <= 9) chk_bit("stall_in_ready", u_in_ready, 1'b0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("stall");

    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      uv = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 9)] : int'($urandom_range(0, 2047));
      sv = ($urandom_range(0, 3) == 0) ? -pool[$urandom_range(0, 9)] : int'($urandom_range(0, 4095));
      send(uv, sv, 1'($urandom_range(0, 1)), 1'b0, zero_r, zero_r);
      if ($urandom_range(0, 4) == 0) tick();
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drain("random");

    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(100 + k, -100 - k, 1'b1, 1'b0, zero_r, zero_r);
    #2;
    rst_n = 1'b0;
    #1;
    chk_bit("async_reset_u_out_valid", u_out_valid, 1'b0);
    chk_bit("async_reset_s_out_valid", s_out_valid, 1'b0);
    chk_bit("async_reset_in_ready", u_in_ready, 1'b1);
    chk_res("async_reset_s_fields", '{s_sign, 8'(s_exp), 8'(s_mant), s_zero, s_inx, s_ovf}, zero_r);
    qu.delete();
    qs.delete();
    tick();
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk_bit("post_reset_no_output", u_out_valid | s_out_valid, 1'b0);
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
